// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now, adder later).
// Holds the common FSM encoding and the handshake helpers.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned ARITH_MIN_WIDTH = 1;
    localparam int unsigned ARITH_MAX_WIDTH = 64;

    // Valid/ready: a transfer happens on a rising clk edge where both valid and ready are high.
    // Valid never waits on ready; ready may depend on state only.
    localparam logic HS_IDLE = 1'b0;
    localparam logic HS_ACTIVE = 1'b1;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock,
// with valid/ready channels on operands and result.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             bo;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .diff (d),
        .bout (bo)
    );

    // The result register doubles as the shift register: new bits enter at the MSB.
    always_comb begin
        diff_next = diff >> 1;
        diff_next[WIDTH-1] = d;
    end

    assign borrow = br;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            diff      <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= HS_ACTIVE;
                    if (hs_fire(in_valid, in_ready)) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        br       <= 1'b0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        in_ready <= HS_IDLE;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    diff <= diff_next;
                    br   <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // d is the final result MSB, so overflow is known on this edge.
                        overflow  <= (a_msb != b_msb) && (d != a_msb);
                        busy      <= 1'b0;
                        out_valid <= HS_ACTIVE;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (hs_fire(out_valid, out_ready)) begin
                        out_valid <= HS_IDLE;
                        in_ready  <= HS_ACTIVE;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance and a 1-bit instance
// share clock and reset; expected values are hand-computed constants.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, b8, diff8;
    logic       borrow8, overflow8, busy8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] a1, b1, diff1;
    logic       borrow1, overflow1, busy1;

    int n_cmp;
    int n_fail;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .diff      (diff8),
        .borrow    (borrow8),
        .overflow  (overflow8),
        .busy      (busy8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .diff      (diff1),
        .borrow    (borrow1),
        .overflow  (overflow1),
        .busy      (busy1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Present operands, accept, wait for out_valid, check result and latency.
    task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        check({tag, "_busy"}, 64'(busy8), 64'(1));
        check({tag, "_in_ready_low"}, 64'(in_ready8), 64'(0));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid8 && n < 20);
        check({tag, "_latency"}, 64'(n), 64'(8));
        check({tag, "_diff"}, 64'(diff8), 64'(ed));
        check({tag, "_borrow"}, 64'(borrow8), 64'(eb));
        check({tag, "_overflow"}, 64'(overflow8), 64'(eo));
    endtask

    task automatic take8(input string tag);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        check({tag, "_out_valid_fell"}, 64'(out_valid8), 64'(0));
        check({tag, "_in_ready_rose"}, 64'(in_ready8), 64'(1));
    endtask

    initial begin
        int seen;
        int last;
        int pulses;
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;

        // reset state
        #2;
        check("rst_in_ready", 64'(in_ready8), 64'(0));
        check("rst_out_valid", 64'(out_valid8), 64'(0));
        check("rst_diff", 64'(diff8), 64'(0));
        check("rst_flags", 64'({borrow8, overflow8, busy8}), 64'(0));
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_before_edge", 64'(in_ready8), 64'(0));
        @(posedge clk); #1;
        check("rst_in_ready_after_edge", 64'(in_ready8), 64'(1));
        check("rst_in_ready1_after_edge", 64'(in_ready1), 64'(1));

        // basic subtractions
        run_op8("op_35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        take8("op_35_12");
        run_op8("op_12_35", 8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
        take8("op_12_35");
        run_op8("op_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        take8("op_80_01");
        run_op8("op_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        take8("op_7f_ff");
        run_op8("op_eq", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
        take8("op_eq");

        // stall in DONE with a competing in_valid
        run_op8("stall", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        in_valid8 = 1'b1;
        a8 = 8'hAA;
        b8 = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", 64'(out_valid8), 64'(1));
            check("stall_diff", 64'({diff8, borrow8, overflow8}), 64'({8'h23, 1'b0, 1'b0}));
            check("stall_in_ready", 64'(in_ready8), 64'(0));
        end
        in_valid8 = 1'b0;
        take8("stall");
        @(posedge clk); #1;
        check("stall_ignored_busy", 64'(busy8), 64'(0));
        check("stall_ignored_out_valid", 64'(out_valid8), 64'(0));

        // async reset in the middle of BUSY
        a8 = 8'h35;
        b8 = 8'h12;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid8), 64'(0));
        check("midrst_diff", 64'(diff8), 64'(0));
        check("midrst_flags", 64'({borrow8, overflow8, busy8, in_ready8}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready8), 64'(1));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check("midrst_no_out_valid", 64'(seen), 64'(0));
        run_op8("op_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        take8("op_05_03");

        // WIDTH=1: single op 0-1
        a1 = 1'b0;
        b1 = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        check("w1_busy", 64'(busy1), 64'(1));
        @(posedge clk); #1;
        check("w1_out_valid", 64'(out_valid1), 64'(1));
        check("w1_result", 64'({diff1, borrow1, overflow1}), 64'(3'b111));
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("w1_in_ready", 64'(in_ready1), 64'(1));

        // WIDTH=1 back-to-back: one result every 3 cycles
        a1 = 1'b1;
        b1 = 1'b0;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        last = -1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid1) begin
                check("w1_b2b_result", 64'({diff1, borrow1, overflow1}), 64'(3'b100));
                if (last >= 0) check("w1_b2b_period", 64'(i - last), 64'(3));
                last = i;
                pulses++;
            end
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b0;
        check("w1_b2b_pulses", 64'(pulses), 64'(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
